// File: rtl/vfpu_lane_sequencer.sv
// Vector FP lane sequencer: walks a job's active-lane mask, offering one lane
// per handshake to a shared FPU issue port, and bounds in-flight operations.

// Leading-one detector: index of the most significant set bit of i_vec.
module vfpu_lod #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Ascending scan; the highest set bit overwrites any lower hit.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

module vfpu_lane_sequencer #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned OP_WIDTH  = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         job_valid_i,
  output logic                         job_ready_o,
  input  logic [NUM_LANES-1:0]         job_mask_i,
  input  logic [OP_WIDTH-1:0]          job_op_i,
  output logic                         issue_valid_o,
  input  logic                         issue_ready_i,
  output logic [$clog2(NUM_LANES)-1:0] issue_lane_o,
  output logic [OP_WIDTH-1:0]          issue_op_o,
  output logic                         issue_last_o,
  input  logic                         resp_valid_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int unsigned LANE_W = $clog2(NUM_LANES);
  localparam int unsigned CNT_W  = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [NUM_LANES-1:0] r_mask;
  logic [NUM_LANES-1:0] w_mask_nxt;
  logic [NUM_LANES-1:0] w_mask_rev;
  logic [OP_WIDTH-1:0]  r_op;
  logic [OP_WIDTH-1:0]  w_op_nxt;
  logic [CNT_W-1:0]     r_outst;
  logic [CNT_W-1:0]     w_outst_cnt;
  logic [CNT_W-1:0]     w_outst_nxt;
  logic [LANE_W-1:0]    w_lod_idx;
  logic [LANE_W-1:0]    w_lane;
  logic                 w_lod_found;
  logic                 w_issue_valid;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_err;

  // Reverse the pending mask so the leading-one detector finds the lowest lane.
  always_comb begin
    w_mask_rev = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      w_mask_rev[i] = r_mask[NUM_LANES-1-i];
    end
  end

  vfpu_lod #(
    .WIDTH (NUM_LANES)
  ) u_lod (
    .i_vec   (w_mask_rev),
    .o_idx   (w_lod_idx),
    .o_found (w_lod_found)
  );

  assign w_lane        = LANE_W'(NUM_LANES - 1) - w_lod_idx;
  assign w_last        = (r_mask != '0) && ((r_mask & (r_mask - NUM_LANES'(1))) == '0);
  assign w_issue_valid = (r_state == S_RUN) && w_lod_found && (r_outst < CNT_W'(MAX_OUTST));
  assign w_hs          = w_issue_valid && issue_ready_i;

  // Outstanding-count update; a response with nothing in flight is flagged, not counted.
  always_comb begin
    w_outst_cnt = r_outst;
    w_err       = 1'b0;
    if (w_hs && !resp_valid_i) begin
      w_outst_cnt = r_outst + CNT_W'(1);
    end else if (!w_hs && resp_valid_i) begin
      if (r_outst == '0) begin
        w_err = 1'b1;
      end else begin
        w_outst_cnt = r_outst - CNT_W'(1);
      end
    end
  end

  // Next-state and next-register logic; clear overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_op_nxt    = r_op;
    w_outst_nxt = w_outst_cnt;
    case (r_state)
      S_IDLE: begin
        if (job_valid_i) begin
          w_mask_nxt  = job_mask_i;
          w_op_nxt    = job_op_i;
          w_state_nxt = (job_mask_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_hs) begin
          w_mask_nxt = r_mask & ~(NUM_LANES'(1) << w_lane);
          if (w_last) begin
            w_state_nxt = (w_outst_cnt == '0) ? S_DONE : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_outst_cnt == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (clear_i) begin
      w_state_nxt = S_IDLE;
      w_mask_nxt  = '0;
      w_op_nxt    = '0;
      w_outst_nxt = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_op    <= '0;
      r_outst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_op    <= w_op_nxt;
      r_outst <= w_outst_nxt;
    end
  end

  assign job_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);
  assign issue_valid_o = w_issue_valid;
  assign issue_lane_o  = w_lane;
  assign issue_op_o    = r_op;
  assign issue_last_o  = w_last;
  assign err_o         = w_err;

endmodule
